apb_tb_mbox: RTL

- APB3 completer acting as the simulation host mailbox. It is the responder side of the debug/test APB initiator tasks.
- CPU or bench software writes console characters, an end-of-test code and a scratch word. The host side drains console characters, observes the end flag and posts a fromhost word that raises an interrupt.
- Sits on a peripheral APB segment in the simulation SoC. Replaces SRAM tohost polling with a handshaked channel.

---
 rtl/apb_tb_mbox.sv | 121 ++++++++++++
 1 files changed

// File: rtl/apb_tb_mbox.sv
// rtl/apb_tb_mbox.sv - APB3 simulation host mailbox: console FIFO, end-of-test code, scratch, fromhost word
module apb_tb_mbox #(
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic [3:0]            pstrb,
    input  logic [2:0]            pprot,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pslverr,
    output logic                  pready,
    output logic                  con_valid,
    output logic [7:0]            con_data,
    input  logic                  con_ready,
    output logic                  end_valid,
    output logic [31:0]           end_code,
    input  logic                  fromhost_wr,
    input  logic [31:0]           fromhost_data,
    output logic                  irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(WAIT_CYCLES + 1) + 1;
    localparam int OW = ADDR_WIDTH - 2;
    localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_CYCLES);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [OW-1:0] OFF_CON  = OW'(0);
    localparam logic [OW-1:0] OFF_STAT = OW'(1);
    localparam logic [OW-1:0] OFF_END  = OW'(2);
    localparam logic [OW-1:0] OFF_FH   = OW'(3);
    localparam logic [OW-1:0] OFF_SCR  = OW'(4);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, rptr_q, count;
    logic [WW-1:0] wcnt_q;
    logic          end_valid_q, fh_pend_q;
    logic [31:0]   end_code_q, scratch_q, fh_data_q;
    logic [31:0]   rdata_d;
    logic          err_d;
    logic [OW-1:0] off;
    logic          full, empty, pop, push, access, stall;
    logic          unused_ok;

    assign unused_ok = ^{pprot, paddr[1:0]};
    assign off    = paddr[ADDR_WIDTH-1:2];
    assign count  = wptr_q - rptr_q;
    assign full   = (count == DEPTH);
    assign empty  = (count == '0);
    assign pop    = !empty && con_ready;
    assign access = psel && penable;
    // Only a CON_TX write into a full FIFO stalls; a same-cycle pop frees the slot.
    assign stall  = (off == OFF_CON) && pwrite && full && !pop;
    assign pready = rstn && access && (wcnt_q == WAIT_MAX) && !stall;
    assign push   = pready && (off == OFF_CON) && pwrite;

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        case (off)
            OFF_CON:  ;
            OFF_STAT: if (pwrite) err_d = 1'b1;
                      else rdata_d = {12'd0, fh_pend_q, end_valid_q, empty, full, 8'd0, 8'(count)};
            OFF_END:  if (!pwrite) rdata_d = end_code_q;
            OFF_FH:   if (pwrite) err_d = 1'b1;
                      else rdata_d = fh_data_q;
            OFF_SCR:  if (!pwrite) rdata_d = scratch_q;
            default:  err_d = 1'b1;
        endcase
    end

    assign prdata    = pready ? rdata_d : 32'd0;
    assign pslverr   = pready ? err_d : 1'b0;
    assign con_valid = !empty;
    assign con_data  = empty ? 8'd0 : mem_q[rptr_q[AW-1:0]];
    assign end_valid = end_valid_q;
    assign end_code  = end_code_q;
    assign irq       = fh_pend_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= pwdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wcnt_q      <= '0;
            end_valid_q <= 1'b0;
            end_code_q  <= '0;
            scratch_q   <= '0;
            fh_pend_q   <= 1'b0;
            fh_data_q   <= '0;
        end else begin
            // Counter saturates at WAIT_MAX so a stalled transfer completes as soon as space appears.
            if (!access || pready)      wcnt_q <= '0;
            else if (wcnt_q != WAIT_MAX) wcnt_q <= wcnt_q + 1'b1;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (pready && pwrite && (off == OFF_END) && !end_valid_q) begin
                end_valid_q <= 1'b1;
                end_code_q  <= pwdata;
            end
            if (pready && pwrite && (off == OFF_SCR)) begin
                for (int b = 0; b < 4; b++)
                    if (pstrb[b]) scratch_q[b*8 +: 8] <= pwdata[b*8 +: 8];
            end
            if (fromhost_wr) begin
                fh_pend_q <= 1'b1;
                fh_data_q <= fromhost_data;
            end else if (pready && !pwrite && (off == OFF_FH)) begin
                fh_pend_q <= 1'b0;
            end
        end
    end
endmodule
